// File: rtl/if_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer.
package if_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_INC    = 4;

    typedef enum logic [0:0] {
        RUN,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Bundle of text-memory, redirect and decode-handshake signals of the fetch sequencer.
interface if_fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    import if_pkg::*;

    logic [ADDR_W-1:0]  mem_raddr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               inst_valid;
    logic               inst_ready;
    logic [INSTR_W-1:0] inst;
    logic [ADDR_W-1:0]  inst_pc;
    logic               halted;
    logic               fetch_fault;

    modport master (
        output mem_raddr,
        input  mem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        output halted,
        output fetch_fault
    );

    modport slave (
        input  mem_raddr,
        output mem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        input  halted,
        input  fetch_fault
    );

endinterface

// File: rtl/fetch_queue.sv
// FIFO of {pc, instr} pairs with a registered head; an empty queue presents pc=0 / NOP.
module fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic               pop,
    input  logic               flush,
    output logic               full,
    output logic               empty,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               do_push, do_pop;

    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty && !flush;
    // A push into a full queue is legal only when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr_q]    <= push_pc;
            instr_mem[wr_ptr_q] <= push_instr;
        end
    end

    assign head_pc    = empty ? '0 : pc_mem[rd_ptr_q];
    assign head_instr = empty ? NOP_INSTR : instr_mem[rd_ptr_q];

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns fetch_pc, queues fetched words, handles redirect and halt.
// Optional misaligned-redirect fault checking is enabled by defining FETCH_MISALIGN_CHK_EN.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int unsigned     ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned     TEXT_BYTES = 128,
    parameter int unsigned     QDEPTH     = 2
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_ctrl_if.master   bus
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(TEXT_BYTES - 4);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] target_pc;
    logic              pc_in_range, target_in_range;
    logic              q_push, q_pop, q_flush, q_full, q_empty;

`ifdef FETCH_MISALIGN_CHK_EN
    logic fault_q, fault_d;
    logic misaligned;

    assign misaligned = (bus.redirect_pc[1:0] != 2'b00);
    assign target_pc  = bus.redirect_pc;
`else
    assign target_pc  = bus.redirect_pc & ~ADDR_W'(3);
`endif

    assign pc_in_range     = (fetch_pc_q <= LAST_PC);
    assign target_in_range = (target_pc <= LAST_PC);
    assign q_pop           = !q_empty && bus.inst_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        q_push     = 1'b0;
        q_flush    = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        fault_d    = fault_q;
`endif
        if (bus.redirect_valid) begin
            q_flush    = 1'b1;
            fetch_pc_d = target_pc;
            // Out-of-range target leaves RUN alone; the next fetch opportunity halts.
            state_d    = target_in_range ? RUN : state_q;
`ifdef FETCH_MISALIGN_CHK_EN
            fault_d    = misaligned;
            if (misaligned) begin
                state_d = HALT;
            end
`endif
        end else begin
            case (state_q)
                RUN: begin
                    if (!pc_in_range) begin
                        state_d = HALT;
                    end else if (!q_full || q_pop) begin
                        q_push     = 1'b1;
                        fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
                    end
                end
                HALT:    state_d = HALT;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign bus.fetch_fault = fault_q;
`else
    assign bus.fetch_fault = 1'b0;
`endif

    fetch_queue #(
        .ADDR_W (ADDR_W),
        .DEPTH  (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .push_pc    (fetch_pc_q),
        .push_instr (bus.mem_rdata),
        .pop        (q_pop),
        .flush      (q_flush),
        .full       (q_full),
        .empty      (q_empty),
        .head_pc    (bus.inst_pc),
        .head_instr (bus.inst)
    );

    assign bus.mem_raddr  = fetch_pc_q;
    assign bus.inst_valid = !q_empty;
    assign bus.halted     = (state_q == HALT);

endmodule
